cas_sort_pipe: RTL
==================

# cas_sort_pipe

Parametrised, pipelined sorting network for the DSC sorting datapath and the successor of the fixed 4-lane combinational `cas4`. Sorts `NUM_INPUTS` unsigned `BITS`-wide lanes with an odd-even transposition network built from compare-and-swap (CAS) cells, with one register stage per network stage. Sort direction is selectable per vector, and one vector per enabled cycle can be accepted. It sits between the binary-input capture logic and downstream consumers that need ordered operands.

## Interface
- `NUM_INPUTS`, default 4: number of lanes; must be even and ≥2.
- `BITS`, default 8: width of each lane, unsigned.
- `IDXW`, default 2: index tag width; must be ≥ clog2(`NUM_INPUTS`). Only used when `CAS_SORT_INDEX_EN` is defined.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: global advance. When it is low, the whole pipeline holds.
- `in_valid`, in, 1: the input vector is present.
- `in_dir`, in, 1: sort direction. 0 = descending (lane 0 largest, the `cas4` convention); 1 = ascending.
- `in_data`, in, `NUM_INPUTS*BITS`: flattened input vector. Lane k occupies bits [k*BITS +: BITS].
- `out_valid`, out, 1: the sorted vector is present.
- `out_data`, out, `NUM_INPUTS*BITS`: sorted vector, with the same lane packing as `in_data`.
- `out_idx`, out, `NUM_INPUTS*IDXW`: source-lane index of each output lane. Present only with `CAS_SORT_INDEX_EN`.

## Operation
- The network has `NUM_INPUTS` stages.
  - Stage s compares pairs (2j, 2j+1) when s is even, and pairs (2j+1, 2j+2) when s is odd.
  - Each stage is followed by a register that holds data, the valid bit, the direction bit and (optionally) the index tags.
- CAS rule for a pair (lo, hi), where lo is the lower lane number:
  - Descending: swap only if lane lo < lane hi.
  - Ascending: swap only if lane lo > lane hi.
  - Equal values never swap, so the sort is stable: tied values keep their original lane order.
- The direction is captured with the vector and travels with it. Vectors of mixed direction may be in flight at the same time.
- When `en`=1, every stage register loads from its preceding stage. Stage 0 loads `in_valid`, `in_dir` and `in_data`.
- When `en`=0, all registers hold. `in_valid` is ignored, and the vector presented in that cycle is dropped, not queued.
- A bubble (`in_valid`=0 with `en`=1) propagates as a stage with valid=0. The data registers still load.
- The output is all-zero only after reset. Outside reset, `out_data` shows the last-stage contents even when `out_valid`=0, and consumers must qualify it with `out_valid`.
- All comparisons are unsigned and full width. There is no arithmetic, so no width growth and no wrap-around.

## Timing
- Latency is exactly `NUM_INPUTS` enabled cycles.
  - A vector sampled at rising edge t with `en`=1 appears on the outputs, with `out_valid`=1, after edge t+`NUM_INPUTS`−1, provided `en` stays high throughout.
  - Each cycle with `en`=0 adds one cycle of latency.
- Throughput is one vector per enabled cycle. There is no backpressure output.
- Reset while `rst`=0 (asynchronous, mid-operation included): all valid bits, data, direction bits and index tags go to 0 immediately.
  - So `out_valid`=0, `out_data`=0 and `out_idx`=0.
  - In-flight vectors are discarded.
  - The first edge after `rst` rises may capture input normally.
- Outputs are driven directly from registers, with no combinational path from input to output.
- The critical path is one CAS comparator plus a mux per stage.

## Configuration
- `CAS_SORT_INDEX_EN` defined:
  - Each lane carries an `IDXW`-bit tag, initialised to k at stage 0 for lane k.
  - Tags swap together with the data.
  - `out_idx` reports, for each output lane, the input lane its value came from.
- `CAS_SORT_INDEX_EN` undefined:
  - No tag registers exist and `out_idx` is not present on the port list.
  - Data behaviour is identical in both configurations.

## Test plan
- Descending sort, defaults, `en`=1, lanes 0..3 = 17, 200, 5, 99, `in_dir`=0 → four edges later `out_valid`=1, out lanes 0..3 = 200, 99, 17, 5, `out_idx` = 1, 3, 0, 2.
- Ascending sort, same data with `in_dir`=1 → out lanes = 5, 17, 99, 200, `out_idx` = 2, 0, 3, 1.
- Ties, lanes = 7, 7, 3, 7, descending → out = 7, 7, 7, 3, `out_idx` = 0, 1, 3, 2.
- Back-to-back and stall:
  - Stimulus: 6 random vectors on consecutive cycles with alternating `in_dir`, with `en` held low for 3 cycles after the second vector.
  - Required: 6 `out_valid` pulses, in input order, each output correctly ordered for its own direction. The pulses after the stall arrive 3 cycles later. No vector is duplicated or lost. A vector presented during the `en`=0 window never appears.
- Reset mid-flight: 2 vectors in flight, then drop `rst` asynchronously between edges → `out_valid`=0 and `out_data`=0 immediately. After `rst` is released, no output appears until a new vector is injected.
- Scaled configuration, `NUM_INPUTS`=8, `BITS`=16, `IDXW`=3: 1000 random vectors → every output is monotone in its direction, is a permutation of its input (checked via `out_idx`), and arrives with a latency of 8.

Source files
------------

// File: rtl/cas_sort_pipe.sv
// cas_sort_pipe: pipelined odd-even transposition sorting network.
// Sorts NUM_INPUTS unsigned BITS-wide lanes in NUM_INPUTS register stages.
// Direction is chosen per vector: 0 = descending (lane 0 largest), 1 = ascending.
//
// Optional feature macro: CAS_SORT_INDEX_EN
//   defined   -> every lane carries an IDXW-bit source-lane tag and out_idx
//                reports the input lane each output value came from.
//   undefined -> no tag registers and no out_idx port; data path unchanged.
//
// Valid semantics: in_valid marks a vector on in_data/in_dir and is sampled
// only on rising edges where en=1 (vectors offered while en=0 are dropped).
// out_valid marks out_data/out_idx as a sorted vector for exactly one enabled
// edge. There is no ready signal; the pipeline advances only on en.
module cas_sort_pipe #(
  parameter int NUM_INPUTS = 4,
  parameter int BITS       = 8,
  parameter int IDXW       = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic                       in_dir,
  input  logic [NUM_INPUTS*BITS-1:0] in_data,
  output logic                       out_valid,
  output logic [NUM_INPUTS*BITS-1:0] out_data
`ifdef CAS_SORT_INDEX_EN
  ,
  output logic [NUM_INPUTS*IDXW-1:0] out_idx
`endif
);

  localparam int N  = NUM_INPUTS;
  localparam int DW = NUM_INPUTS * BITS;
`ifdef CAS_SORT_INDEX_EN
  localparam int TW = NUM_INPUTS * IDXW;
`endif

  // Reject unsupported configurations at elaboration time.
  if (NUM_INPUTS < 2 || (NUM_INPUTS % 2) != 0 || IDXW < $clog2(NUM_INPUTS)) begin : g_bad_cfg
    $error("cas_sort_pipe: NUM_INPUTS must be even and >= 2, IDXW >= clog2(NUM_INPUTS)");
  end

  // Stage registers: index s holds the result of network stage s.
  logic [DW-1:0] data_q  [N];
  logic          valid_q [N];
  logic          dir_q   [N];

  // Inputs to each network stage and the compare-and-swap result.
  logic [DW-1:0] src_data  [N];
  logic          src_valid [N];
  logic          src_dir   [N];
  logic [DW-1:0] cas_data  [N];

  logic [BITS-1:0] lo_val;
  logic [BITS-1:0] hi_val;
  logic            swap;

`ifdef CAS_SORT_INDEX_EN
  logic [TW-1:0]   idx_q   [N];
  logic [TW-1:0]   src_idx [N];
  logic [TW-1:0]   cas_idx [N];
  logic [IDXW-1:0] lo_tag;
  logic [IDXW-1:0] hi_tag;
`endif

  // Stage 0 reads the input port, every later stage reads the previous register.
  always_comb begin
    src_data[0]  = in_data;
    src_valid[0] = in_valid;
    src_dir[0]   = in_dir;
    for (int s = 1; s < N; s++) begin
      src_data[s]  = data_q[s-1];
      src_valid[s] = valid_q[s-1];
      src_dir[s]   = dir_q[s-1];
    end
`ifdef CAS_SORT_INDEX_EN
    src_idx[0] = '0;
    for (int k = 0; k < N; k++) begin
      src_idx[0][k*IDXW +: IDXW] = IDXW'(k);
    end
    for (int s = 1; s < N; s++) begin
      src_idx[s] = idx_q[s-1];
    end
`endif
  end

  // Compare-and-swap layer of every stage: even stages pair (2j,2j+1), odd
  // stages pair (2j+1,2j+2). Equal values never swap, which keeps ties stable.
  always_comb begin
    lo_val = '0;
    hi_val = '0;
    swap   = 1'b0;
`ifdef CAS_SORT_INDEX_EN
    lo_tag = '0;
    hi_tag = '0;
`endif
    for (int s = 0; s < N; s++) begin
      cas_data[s] = src_data[s];
`ifdef CAS_SORT_INDEX_EN
      cas_idx[s]  = src_idx[s];
`endif
      for (int j = 0; j < N - 1; j++) begin
        if ((j % 2) == (s % 2)) begin
          lo_val = src_data[s][j*BITS +: BITS];
          hi_val = src_data[s][(j+1)*BITS +: BITS];
          swap   = src_dir[s] ? (lo_val > hi_val) : (lo_val < hi_val);
          if (swap) begin
            cas_data[s][j*BITS +: BITS]     = hi_val;
            cas_data[s][(j+1)*BITS +: BITS] = lo_val;
`ifdef CAS_SORT_INDEX_EN
            lo_tag = src_idx[s][j*IDXW +: IDXW];
            hi_tag = src_idx[s][(j+1)*IDXW +: IDXW];
            cas_idx[s][j*IDXW +: IDXW]     = hi_tag;
            cas_idx[s][(j+1)*IDXW +: IDXW] = lo_tag;
`endif
          end
        end
      end
    end
  end

  // Pipeline registers: clear on reset, advance together when en is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < N; s++) begin
        data_q[s]  <= '0;
        valid_q[s] <= 1'b0;
        dir_q[s]   <= 1'b0;
`ifdef CAS_SORT_INDEX_EN
        idx_q[s]   <= '0;
`endif
      end
    end else if (en) begin
      for (int s = 0; s < N; s++) begin
        data_q[s]  <= cas_data[s];
        valid_q[s] <= src_valid[s];
        dir_q[s]   <= src_dir[s];
`ifdef CAS_SORT_INDEX_EN
        idx_q[s]   <= cas_idx[s];
`endif
      end
    end
  end

  assign out_valid = valid_q[N-1];
  assign out_data  = data_q[N-1];
`ifdef CAS_SORT_INDEX_EN
  assign out_idx   = idx_q[N-1];
`endif

endmodule
